encode_packet: RTL and testbench
================================

Name: encode_packet

Overview:
- TX-side counterpart of the Aurora packet decoder.
- Accepts one DFX word (DATA_WIDTH payload + ADDR_WIDTH address = 1034 bits) over a valid/ready handshake.
- Slices the word into NUMBER_PACKET 256-bit Aurora beats, each carrying a 7-bit header (source router ID, packet number).
- Streams the beats to the Aurora TX user interface with backpressure; sits between the DFX data source and the Aurora lane.

Parameters:
- DATA_WIDTH, 1024, DFX payload width.
- ADDR_WIDTH, 10, DFX address width.
- DATA_DFX_WIDTH, DATA_WIDTH+ADDR_WIDTH, width of the encoded word (1034).
- AURORA_DATA_WIDTH, 256, Aurora beat width.
- NUMBER_PACKET, 5, beats per DFX word.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- src_router_id  in  2  router ID placed in header; sampled at acceptance.
- data_dfx_in  in  DATA_DFX_WIDTH  DFX word to send.
- valid_dfx_in  in  1  data_dfx_in valid.
- ready_dfx_in  out  1  encoder can accept a word.
- data_send  out  AURORA_DATA_WIDTH  beat to Aurora TX.
- valid_send  out  1  data_send valid.
- ready_send  in  1  Aurora TX ready (tready).
- encode_done  out  1  one-cycle pulse after the last beat is accepted.
- busy  out  1  high while not IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; beat counter 0; capture register 0. Reset mid-operation abandons the partial word; no further beats are sent.
- States:
  - IDLE -> SEND when valid_dfx_in && ready_dfx_in.
  - SEND -> DONE on the handshake of beat NUMBER_PACKET-1.
  - DONE -> IDLE unconditionally.
  - Unused state encoding -> IDLE.
- ready_dfx_in: registered; equals (next_state==IDLE). It is 1 from the first cycle after reset release and 0 in SEND and DONE.
- Acceptance (IDLE, valid_dfx_in && ready_dfx_in): capture data_dfx_in and src_router_id; load beat 0 into data_send; valid_send=1 next cycle; beat counter=0.
- Beat format, beat n:
  - [1:0]=src_router_id, [4:2]=n, [6:5]=2'b00 (see Optional Feature).
  - n<NUMBER_PACKET-1: [255:7]=word[n*249 +: 249].
  - n=NUMBER_PACKET-1: [44:7]=word[1033:996], [255:45]=0.
- Handshake in SEND: a beat transfers when valid_send && ready_send. While valid_send && !ready_send, data_send and valid_send hold stable.
  - On transfer of beat n<4: load beat n+1 the same edge (no bubble); counter increments.
  - On transfer of beat 4: valid_send->0, data_send->0, state->DONE.
- encode_done: registered; 1 exactly during the DONE cycle; otherwise 0.
- busy = state != IDLE, decoded from the state register.
- Latency with ready_send held 1: acceptance at edge 0; beats on cycles 1..5; encode_done in cycle 6; ready_dfx_in=1 in cycle 7. Minimum spacing between accepted words is 7 cycles.
- ready_send toggling while valid_send=0 has no effect. valid_dfx_in while busy is ignored and the word is not captured.
- Header round-trip requirement: the decoder reassembles the exact 1034-bit word.

Optional Feature:
- Macro: ENCODE_PKT_PARITY_EN.
- Defined: header bit 5 = even parity (XOR reduction) of beat bits [255:7], computed on the registered beat value. Zero-padded bits count as 0. Bit 6 stays 0.
- Undefined: bits [6:5] always 0. No parity logic is synthesized.

Test Plan:
- Reset then idle: rst_n low for 3 cycles -> all outputs 0. One cycle after release, ready_dfx_in=1 and busy=0.
- Single word, ready_send=1: word = {10'h2A5, 1024'h(incrementing bytes)}, src_router_id=2'b10.
  - Exactly 5 beats on consecutive cycles with headers 7'h02, 7'h06, 7'h0A, 7'h0E, 7'h12.
  - Beat 4 [44:7]=word[1033:996], [255:45]=0.
  - encode_done for 1 cycle in cycle 6.
- Backpressure: ready_send low for 3 cycles on beat 2 -> data_send/valid_send held bit-identical, no skipped or duplicated beat, encode_done delayed 3 cycles.
- Back-to-back: valid_dfx_in held high with two words queued -> second accepted only when ready_dfx_in returns (7 cycles later). valid_dfx_in during busy does not corrupt beats.
- Reset mid-packet: assert rst_n after beat 1 transfers -> valid_send=0 immediately. After release no residual beats; a new word encodes from beat 0.
- With ENCODE_PKT_PARITY_EN: all-ones word -> beats 0–3 bit5=1 (249 ones), beat 4 bit5=0 (38 ones). Without the macro, bit5=0 on every beat.

Source files
------------

// File: rtl/encode_packet.sv
// Aurora TX packet encoder: slices one 1034-bit DFX word into five 256-bit beats with 7-bit headers.
// Optional macro ENCODE_PKT_PARITY_EN puts even parity of the beat payload in header bit 5.
module encode_packet #(
  parameter int DATA_WIDTH        = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
  parameter int AURORA_DATA_WIDTH = 256,
  parameter int NUMBER_PACKET     = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   src_router_id,
  input  logic [DATA_DFX_WIDTH-1:0]    data_dfx_in,
  input  logic                         valid_dfx_in,
  output logic                         ready_dfx_in,
  output logic [AURORA_DATA_WIDTH-1:0] data_send,
  output logic                         valid_send,
  input  logic                         ready_send,
  output logic                         encode_done,
  output logic                         busy
);

  localparam int HDR_W   = 7;
  localparam int CHUNK_W = AURORA_DATA_WIDTH - HDR_W;
  localparam int LAST_W  = DATA_DFX_WIDTH - (NUMBER_PACKET - 1) * CHUNK_W;
  localparam int IDX_W   = $clog2(DATA_DFX_WIDTH);
  localparam logic [2:0] LastIdx = 3'(NUMBER_PACKET - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [2:0]                cnt_q;
  logic [DATA_DFX_WIDTH-1:0] word_q;
  logic [1:0]                id_q;
  logic                      accept;
  logic                      xfer;

  function automatic logic [AURORA_DATA_WIDTH-1:0] make_beat(
    input logic [DATA_DFX_WIDTH-1:0] word,
    input logic [1:0]                id,
    input logic [2:0]                n
  );
    logic [AURORA_DATA_WIDTH-1:0] b;
    logic [IDX_W-1:0]             base;
    b    = '0;
    base = IDX_W'(32'(n) * CHUNK_W);
    b[1:0] = id;
    b[4:2] = n;
    if (n == LastIdx) begin
      b[HDR_W +: LAST_W] = word[DATA_DFX_WIDTH-1 -: LAST_W];
    end else begin
      b[AURORA_DATA_WIDTH-1:HDR_W] = word[base +: CHUNK_W];
    end
`ifdef ENCODE_PKT_PARITY_EN
    b[5] = ^b[AURORA_DATA_WIDTH-1:HDR_W];
`endif
    return b;
  endfunction

  assign accept = valid_dfx_in && ready_dfx_in && (state_q == StIdle);
  assign xfer   = valid_send && ready_send;
  assign busy   = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = StSend;
      StSend: if (xfer && cnt_q == LastIdx) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      word_q       <= '0;
      id_q         <= '0;
      data_send    <= '0;
      valid_send   <= 1'b0;
      ready_dfx_in <= 1'b0;
      encode_done  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_dfx_in <= (state_d == StIdle);
      encode_done  <= (state_d == StDone);
      case (state_q)
        StIdle: begin
          if (accept) begin
            word_q     <= data_dfx_in;
            id_q       <= src_router_id;
            // Beat 0 comes straight from the input so it is valid the cycle after acceptance.
            data_send  <= make_beat(data_dfx_in, src_router_id, 3'd0);
            valid_send <= 1'b1;
            cnt_q      <= '0;
          end
        end
        StSend: begin
          if (xfer) begin
            if (cnt_q == LastIdx) begin
              data_send  <= '0;
              valid_send <= 1'b0;
            end else begin
              cnt_q     <= cnt_q + 3'd1;
              data_send <= make_beat(word_q, id_q, cnt_q + 3'd1);
            end
          end
        end
        default: begin
          data_send  <= '0;
          valid_send <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encode_packet.sv
// Self-checking bench for encode_packet: directed and random words checked against a shift-based beat model.
module tb_encode_packet;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    src_router_id;
  logic [1033:0] data_dfx_in;
  logic          valid_dfx_in;
  logic          ready_dfx_in;
  logic [255:0]  data_send;
  logic          valid_send;
  logic          ready_send;
  logic          encode_done;
  logic          busy;

  int tests_run    = 0;
  int tests_failed = 0;

  encode_packet dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_router_id (src_router_id),
    .data_dfx_in   (data_dfx_in),
    .valid_dfx_in  (valid_dfx_in),
    .ready_dfx_in  (ready_dfx_in),
    .data_send     (data_send),
    .valid_send    (valid_send),
    .ready_send    (ready_send),
    .encode_done   (encode_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Beat n carries bits [n*249 +: 249] of the word; the final beat naturally zero-fills above bit 37.
  function automatic logic [255:0] exp_beat(input logic [1033:0] w, input logic [1:0] id,
                                            input int n);
    logic [1033:0] sh;
    logic [248:0]  pl;
    logic          par;
    sh  = w >> (n * 249);
    pl  = sh[248:0];
    par = 1'b0;
`ifdef ENCODE_PKT_PARITY_EN
    par = ^pl;
`endif
    return {pl, 1'b0, par, 3'(n), id};
  endfunction

  function automatic logic [1033:0] rand_word();
    logic [1033:0] w;
    w = '0;
    for (int k = 0; k < 33; k++) w = {w[1001:0], 32'($urandom)};
    return w;
  endfunction

  // Sends one word with ready_dfx_in already high; optionally stalls one beat and/or
  // leaves valid_dfx_in asserted with the next word while the encoder is busy.
  task automatic send_word(input logic [1033:0] w, input logic [1:0] id, input int stall_beat,
                           input int stall_len, input logic hold_next,
                           input logic [1033:0] next_w, input logic [1:0] next_id);
    logic [255:0] exp;
    data_dfx_in   = w;
    src_router_id = id;
    valid_dfx_in  = 1'b1;
    ready_send    = 1'b1;
    tick();
    if (hold_next) begin
      data_dfx_in   = next_w;
      src_router_id = next_id;
    end else begin
      valid_dfx_in  = 1'b0;
      data_dfx_in   = rand_word();
      src_router_id = 2'($urandom);
    end
    for (int n = 0; n < 5; n++) begin
      exp = exp_beat(w, id, n);
      check($sformatf("beat%0d_valid", n), 256'(valid_send), 256'(1));
      check($sformatf("beat%0d_data", n), data_send, exp);
      check($sformatf("beat%0d_hdr", n), 256'(data_send[4:0]), 256'({3'(n), id}));
      check($sformatf("beat%0d_busy", n), 256'({busy, ready_dfx_in, encode_done}), 256'(3'b100));
      if (n == stall_beat) begin
        ready_send = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check($sformatf("stall%0d_valid", s), 256'(valid_send), 256'(1));
          check($sformatf("stall%0d_data", s), data_send, exp);
        end
        ready_send = 1'b1;
      end
      tick();
    end
    check("done_pulse", 256'({encode_done, valid_send, busy, ready_dfx_in}), 256'(4'b1010));
    check("done_data", data_send, 256'(0));
    tick();
    check("after_done", 256'({encode_done, valid_send, busy, ready_dfx_in}), 256'(4'b0001));
  endtask

  initial begin
    logic [1033:0] w, w2;
    logic [1:0]    id, id2;
    rst_n         = 1'b0;
    src_router_id = '0;
    data_dfx_in   = '0;
    valid_dfx_in  = 1'b0;
    ready_send    = 1'b0;

    repeat (3) tick();
    check("reset_data", data_send, 256'(0));
    check("reset_ctl", 256'({valid_send, ready_dfx_in, encode_done, busy}), 256'(0));
    rst_n = 1'b1;
    tick();
    check("post_reset", 256'({ready_dfx_in, busy}), 256'(2'b10));

    // Directed word: incrementing bytes with address 0x2A5
    w = '0;
    for (int i = 0; i < 128; i++) w[i*8 +: 8] = 8'(i);
    w[1033:1024] = 10'h2A5;
    send_word(w, 2'b10, -1, 0, 1'b0, '0, '0);

    // ready_send toggling with nothing valid must not produce beats
    for (int i = 0; i < 4; i++) begin
      ready_send = 1'($urandom);
      tick();
      check("idle_toggle", 256'({valid_send, busy}), 256'(0));
    end

    // Backpressure on beat 2
    send_word(rand_word(), 2'b01, 2, 3, 1'b0, '0, '0);

    // All-ones word exercises the parity header bit
    w = '1;
    send_word(w, 2'b11, -1, 0, 1'b0, '0, '0);

    // Back-to-back: second word waits on valid_dfx_in during the first
    w  = rand_word();
    w2 = rand_word();
    send_word(w, 2'b00, -1, 0, 1'b1, w2, 2'b01);
    send_word(w2, 2'b01, 4, 2, 1'b0, '0, '0);

    // Reset after beat 1 transfers
    w = rand_word();
    data_dfx_in   = w;
    src_router_id = 2'b10;
    valid_dfx_in  = 1'b1;
    ready_send    = 1'b1;
    tick();
    valid_dfx_in = 1'b0;
    tick();
    tick();
    check("pre_reset_beat2", data_send, exp_beat(w, 2'b10, 2));
    rst_n = 1'b0;
    #1;
    check("midreset_ctl", 256'({valid_send, busy, encode_done, ready_dfx_in}), 256'(0));
    check("midreset_data", data_send, 256'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_residual", 256'({valid_send, busy}), 256'(0));
    end
    send_word(rand_word(), 2'b11, -1, 0, 1'b0, '0, '0);

    // Random words with random stalls
    for (int r = 0; r < 6; r++) begin
      id = 2'($urandom);
      send_word(rand_word(), id, int'($urandom_range(0, 5)) - 1, int'($urandom_range(1, 3)),
                1'b0, '0, '0);
      repeat ($urandom_range(0, 2)) begin
        ready_send = 1'($urandom);
        tick();
        check("gap_idle", 256'({valid_send, busy}), 256'(0));
      end
    end
    id2 = 2'b00;
    check("final_idle", 256'({valid_send, busy, ready_dfx_in, id2}), 256'(5'b00100));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
